lut_layer_scheduler: RTL and testbench
======================================

// Module: lut_layer_scheduler
// PURPOSE
//  Time-multiplexed evaluator for one layer of LUT neurons with 8-bit fan-in and 1-bit output.
//  Holds all neuron truth tables in one writable table RAM, NUM_NEURONS x 2^IN_BITS x 1 bit.
//  Evaluates one neuron per cycle and assembles the 1-bit results into a layer output vector.
//  Arbitrates the table between a configuration write port and the evaluation datapath.
// PARAMETERS
//  NUM_NEURONS  16  neurons in the layer; must be >= 2
//  IN_BITS      8   fan-in bits per neuron (truth-table index width)
//  NEURON_W     $clog2(NUM_NEURONS)  neuron index width (derived; do not override)
// PORTS
//  clk        in   1                      rising-edge clock
//  rst        in   1                      asynchronous, active-high reset
//  cfg_valid  in   1                      table write request
//  cfg_ready  out  1                      table write accepted this cycle
//  cfg_addr   in   NEURON_W+IN_BITS       {neuron index, table index}
//  cfg_data   in   1                      truth-table bit to store
//  in_valid   in   1                      layer input vector valid
//  in_ready   out  1                      layer input accepted this cycle
//  in_vec     in   NUM_NEURONS*IN_BITS    neuron n input = in_vec[n*IN_BITS +: IN_BITS]
//  out_valid  out  1                      out_vec valid
//  out_ready  in   1                      downstream accepts out_vec
//  out_vec    out  NUM_NEURONS            bit n = output of neuron n
//  busy       out  1                      high in RUN or DRAIN
// BEHAVIOUR
//  Reset values
//   - State goes to IDLE; out_valid=0, out_vec=0, busy=0.
//   - cfg_ready=1 and in_ready=1 per the IDLE equations below.
//   - Table RAM is not reset; contents are undefined until written.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE
//  Handshakes
//   - cfg_ready = (state==IDLE); config has priority over input.
//   - in_ready  = (state==IDLE) && !cfg_valid.
//   - Config write fires when cfg_valid && cfg_ready; table[cfg_addr] <= cfg_data at that edge.
//   - Input fires when in_valid && in_ready.
//  IDLE
//   - On input fire: latch in_vec into an internal register, idx<=0, clear out_vec, go to RUN.
//  RUN
//   - Each cycle, issue a registered read at addr {idx, in_reg[idx*IN_BITS +: IN_BITS]}.
//   - Read data appears one cycle later and is written to out_vec[idx_d], where idx_d = idx delayed one cycle.
//   - idx increments. When idx==NUM_NEURONS-1 is issued, go to DRAIN.
//  DRAIN
//   - Captures the last read result, then goes to DONE with out_valid=1.
//   - Latency from input-fire edge to out_valid=1 is NUM_NEURONS+1 cycles (17 at default).
//  DONE
//   - out_valid=1 and out_vec are held stable until out_ready.
//   - On out_valid && out_ready: out_valid<=0, go to IDLE. out_vec keeps its value until the next input fire.
//   - Back-to-back throughput: one vector per NUM_NEURONS+3 cycles.
//  Boundary conditions
//   - cfg_valid and in_valid both high in IDLE: the config write wins; input waits (in_ready=0).
//   - cfg_valid while not IDLE: held off (cfg_ready=0), so a table being read is never modified.
//   - in_vec changes after acceptance have no effect, because evaluation uses the latched copy.
//   - out_ready high before DONE is ignored.
//   - idx does not wrap: the last address issued is NUM_NEURONS-1.
//   - rst asserted mid-RUN/DRAIN/DONE: aborts immediately to IDLE with reset values; table contents are kept.
//   - Read-during-write cannot occur (writes happen in IDLE only).
// TESTING
//  1. Load table[n][x] = x[5] for all n; in_vec=all 8'h20 -> out_valid 17 cycles after fire, out_vec=16'hFFFF.
//  2. Same table; in_vec neuron n = (n odd ? 8'h20 : 8'h00) -> out_vec=16'hAAAA.
//  3. Assert cfg_valid and in_valid together in IDLE -> write occurs, in_ready=0 that cycle, input accepted next cycle.
//  4. Hold out_ready=0 for 10 cycles after out_valid -> out_vec stable, cfg_ready=0 and in_ready=0 throughout; pulse out_ready -> IDLE next cycle.
//  5. Assert rst at RUN cycle 5 -> out_valid=0 and busy=0 immediately; re-run case 1 -> same result (table preserved).
//  6. Random tables and inputs, 1000 vectors with random out_ready -> out_vec matches reference model; no handshake violations.

Source files
------------

// File: rtl/lut_layer_scheduler.sv
// Purpose: evaluates one layer of 1-bit-output LUT neurons, one neuron per cycle, from a shared truth-table RAM.
// Latency: out_valid rises NUM_NEURONS+1 cycles after input fire; one vector per NUM_NEURONS+3 cycles back to back.
// Backpressure: result held in DONE until out_ready; config and input are refused while a vector is in flight.
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IN_BITS     = 8,
  parameter int NEURON_W    = $clog2(NUM_NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [NEURON_W+IN_BITS-1:0]    cfg_addr,
  input  logic                           cfg_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0] in_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_NEURONS-1:0]         out_vec,
  output logic                           busy
);

  localparam int ADDR_W = NEURON_W + IN_BITS;
  localparam int DEPTH  = NUM_NEURONS << IN_BITS;
  localparam logic [NEURON_W-1:0] LAST = NEURON_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state;
  logic [NEURON_W-1:0]            idx;
  logic [NEURON_W-1:0]            idx_d;
  logic                           rd_vld;
  logic                           rd_data;
  logic [NUM_NEURONS*IN_BITS-1:0] in_reg;
  logic [ADDR_W-1:0]              rd_addr;
  logic                           cfg_fire;
  logic                           in_fire;

  // Truth-table storage; intentionally not reset so it maps onto plain RAM.
  logic table_mem [DEPTH];

  // Config owns the table in IDLE and takes priority over a waiting input.
  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == IDLE) && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  // Neuron idx looks up its own slice of the latched input vector.
  assign rd_addr = {idx, in_reg[idx*IN_BITS +: IN_BITS]};

  // Single-port table: writes only in IDLE, registered reads only in RUN, so they never collide.
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      table_mem[cfg_addr] <= cfg_data;
    end
    if (state == RUN) begin
      rd_data <= table_mem[rd_addr];
    end
  end

  // Scheduler FSM: issue one read per cycle, retire each result one cycle later into out_vec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      idx_d     <= '0;
      rd_vld    <= 1'b0;
      in_reg    <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_vld <= 1'b0;
          if (in_fire) begin
            in_reg  <= in_vec;
            idx     <= '0;
            out_vec <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          idx_d  <= idx;
          rd_vld <= 1'b1;
          if (rd_vld) begin
            out_vec[idx_d] <= rd_data;
          end
          // Stop at the last neuron instead of wrapping idx back to zero.
          if (idx == LAST) begin
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          out_vec[idx_d] <= rd_data;
          rd_vld         <= 1'b0;
          busy           <= 1'b0;
          out_valid      <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          // out_vec is left untouched so it remains readable until the next input fire.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Purpose: self-checking bench for lut_layer_scheduler with a truth-table model and output scoreboard.
// Latency: checks the NUM_NEURONS+1 cycle fire-to-valid latency on directed vectors.
// Backpressure: exercises held-off config, held output, random out_ready and mid-run reset.
`timescale 1ns/1ps
module tb_lut_layer_scheduler;

  localparam int NN = 16;
  localparam int IB = 8;
  localparam int NW = 4;
  localparam int AW = NW + IB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr = '0;
  logic              cfg_data = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NN*IB-1:0]  in_vec = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [NN-1:0]     out_vec;
  logic              busy;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  rnd_rdy  = 1'b0;
  bit  tbl [1 << AW];
  logic [NN-1:0] expq [$];

  lut_layer_scheduler #(.NUM_NEURONS(NN), .IN_BITS(IB)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NN-1:0] model_eval(input logic [NN*IB-1:0] v);
    logic [NN-1:0] r;
    logic [NW-1:0] nn;
    logic [IB-1:0] x;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      nn   = NW'(n);
      x    = v[n*IB +: IB];
      r[n] = tbl[{nn, x}];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic d);
    int w;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    #1;
    w = 0;
    while (!cfg_ready && w < 300) begin
      tick();
      w++;
    end
    if (!cfg_ready) begin
      check("cfg_timeout", 64'(cfg_ready), 64'd1);
    end else begin
      tbl[a] = d;
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [NN*IB-1:0] v);
    int w;
    in_valid = 1'b1;
    in_vec   = v;
    #1;
    w = 0;
    while (!in_ready && w < 300) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("in_timeout", 64'(in_ready), 64'd1);
    end else begin
      expq.push_back(model_eval(v));
      tick();
    end
    in_valid = 1'b0;
    in_vec   = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Count edges from the fire edge until out_valid is seen; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy || out_valid) && w < 300) begin
      tick();
      w++;
    end
    if (busy || out_valid) check("idle_timeout", 64'({busy, out_valid}), 64'd0);
  endtask

  function automatic logic [NN*IB-1:0] fill_vec(input logic [IB-1:0] ev, input logic [IB-1:0] od);
    logic [NN*IB-1:0] v;
    for (int n = 0; n < NN; n++) v[n*IB +: IB] = (n % 2 == 1) ? od : ev;
    return v;
  endfunction

  // Output monitor: scoreboard compare every cycle out_valid is high, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy || out_valid) check("rdy_while_active", 64'({cfg_ready, in_ready}), 64'd0);
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("sb_unexpected", 64'(out_valid), 64'd0);
        end else begin
          check("out_vec", 64'(out_vec), 64'(expq[0]));
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset values
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec",   64'(out_vec),   64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    tick();

    // Case 1: table[n][x] = x[5]; all inputs 8'h20
    for (int a = 0; a < (1 << AW); a++) begin
      logic [AW-1:0] aa;
      aa = AW'(a);
      cfg_write(aa, aa[5]);
    end
    send_vec(fill_vec(8'h20, 8'h20));
    wait_valid(lat);
    check("t1_latency", 64'(lat), 64'd17);
    check("t1_out_vec", 64'(out_vec), 64'hFFFF);
    wait_idle();

    // Case 2: odd neurons see bit 5 set
    send_vec(fill_vec(8'h00, 8'h20));
    wait_valid(lat);
    check("t2_latency", 64'(lat), 64'd17);
    check("t2_out_vec", 64'(out_vec), 64'hAAAA);
    wait_idle();
    check("t2_hold_after_done", 64'(out_vec), 64'hAAAA);

    // Case 3: config and input together, config wins
    cfg_valid = 1'b1; cfg_addr = {4'd3, 8'h20}; cfg_data = 1'b0;
    in_valid = 1'b1;  in_vec = fill_vec(8'h20, 8'h20);
    #1;
    check("t3_in_ready_blocked", 64'(in_ready), 64'd0);
    check("t3_cfg_ready",        64'(cfg_ready), 64'd1);
    tbl[{4'd3, 8'h20}] = 1'b0;
    tick();
    cfg_valid = 1'b0;
    #1;
    check("t3_in_ready_next", 64'(in_ready), 64'd1);
    expq.push_back(model_eval(in_vec));
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("t3_out_vec", 64'(out_vec), 64'hFFF7);
    wait_idle();
    cfg_write({4'd3, 8'h20}, 1'b1);

    // Case 4: hold out_ready low for 10 cycles in DONE
    out_ready = 1'b0;
    send_vec(fill_vec(8'h00, 8'h20));
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_valid_held", 64'(out_valid), 64'd1);
      check("t4_cfg_ready",  64'(cfg_ready), 64'd0);
      check("t4_in_ready",   64'(in_ready),  64'd0);
      check("t4_out_vec",    64'(out_vec),   64'hAAAA);
    end
    out_ready = 1'b1;
    tick();
    check("t4_released",     64'(out_valid), 64'd0);
    check("t4_idle_cfg_rdy", 64'(cfg_ready), 64'd1);

    // Case 5: reset in RUN cycle 5, then rerun case 1
    send_vec(fill_vec(8'h20, 8'h20));
    for (int i = 0; i < 5; i++) tick();
    check("t5_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_busy",      64'(busy),      64'd0);
    check("t5_out_vec",   64'(out_vec),   64'd0);
    check("t5_cfg_ready", 64'(cfg_ready), 64'd1);
    void'(expq.pop_back());
    tick();
    rst = 1'b0;
    tick();
    send_vec(fill_vec(8'h20, 8'h20));
    wait_valid(lat);
    check("t5_latency", 64'(lat), 64'd17);
    check("t5_rerun",   64'(out_vec), 64'hFFFF);
    wait_idle();

    // Case 6: random table, 1000 random vectors, random out_ready, sporadic rewrites
    for (int a = 0; a < (1 << AW); a++) cfg_write(AW'(a), 1'($urandom_range(0, 1)));
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 50) begin
        for (int k = 0; k < 20; k++) cfg_write(AW'($urandom()), 1'($urandom_range(0, 1)));
      end
      send_vec({$urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) tick();
    end
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();
    check("sb_drained", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
